// File: rtl/fir_out_decimator.sv
// Decimates a stream of unsigned FIR output samples, scales each kept sample to 8 bits with
// saturation, and buffers the results in a small show-ahead FIFO that has overflow statistics.
module fir_out_decimator #(
   parameter int DECIM = 2,
   parameter int SHIFT = 4,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic        clr_stat,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic [4:0]  fill,
   output logic [7:0]  ovf_cnt,
   output logic        sat_flag
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]    phase;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [4:0]    count;
   logic [7:0]    mem [DEPTH];

   logic [15:0]   shifted;
   logic          clip;
   logic [7:0]    kept_val;
   logic          kept;
   logic          full;
   logic          pop;
   logic          push;

   // A full FIFO still accepts a kept sample when the head leaves in the same cycle
   always_comb begin
      shifted  = in_data >> SHIFT;
      clip     = shifted > 16'd255;
      kept_val = clip ? 8'hFF : shifted[7:0];
      kept     = in_valid && (phase == 4'd0);
      full     = (count == 5'(DEPTH));
      pop      = (count != 5'd0) && out_ready;
      push     = kept && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         ovf_cnt  <= '0;
         sat_flag <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (in_valid) phase <= (phase == 4'(DECIM - 1)) ? 4'd0 : phase + 4'd1;
         if (push) begin
            mem[wr_ptr] <= kept_val;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 5'd1;
         else if (pop && !push) count <= count - 5'd1;
         // Clearing the statistics wins over any event recorded in the same cycle
         if (clr_stat) begin
            ovf_cnt  <= '0;
            sat_flag <= 1'b0;
         end else begin
            if (kept && !push && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
            if (kept && clip) sat_flag <= 1'b1;
         end
      end
   end

   assign out_valid = (count != 5'd0);
   assign out_data  = mem[rd_ptr];
   assign fill      = count;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator: a queue-based reference model predicts the FIFO
// contents and the statistics, and every step compares the DUT against it.
module tb_fir_out_decimator;

   localparam int DECIM = 2;
   localparam int SHIFT = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        clr_stat;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [4:0]  fill;
   logic [7:0]  ovf_cnt;
   logic        sat_flag;

   int          vectors = 0;
   int          miscompares = 0;

   logic [7:0]  expQ[$];
   int          mPhase = 0;
   int          mOvf = 0;
   logic        mSat = 1'b0;
   logic        justReset = 1'b0;

   fir_out_decimator #(.DECIM(DECIM), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_data(in_data),
      .clr_stat(clr_stat),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .fill(fill),
      .ovf_cnt(ovf_cnt),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle at the falling edge, advances the model, and checks just after the rising edge
   task automatic applyStimulus(input logic rstN, input logic v, input logic [15:0] d,
                                input logic rdy, input logic clr);
      int          sz;
      logic        kept;
      logic        pop;
      logic        push;
      logic        clip;
      logic [15:0] s;
      logic [7:0]  val;
      logic [7:0]  popped;
      @(negedge clk);
      rst_n    = rstN;
      in_valid = v;
      in_data  = d;
      out_ready = rdy;
      clr_stat = clr;
      sz = expQ.size();
      justReset = !rstN;
      if (!rstN) begin
         expQ.delete();
         mPhase = 0;
         mOvf   = 0;
         mSat   = 1'b0;
      end else begin
         pop  = rdy && (sz != 0);
         kept = v && (mPhase == 0);
         s    = d >> SHIFT;
         clip = (s > 16'd255);
         val  = clip ? 8'hFF : s[7:0];
         push = kept && ((sz < DEPTH) || pop);
         if (pop) begin
            popped = expQ.pop_front();
            checkOutput("pop_data", {8'h00, out_data}, {8'h00, popped});
         end
         if (push) expQ.push_back(val);
         if (v) mPhase = (mPhase == DECIM - 1) ? 0 : mPhase + 1;
         if (clr) begin
            mOvf = 0;
            mSat = 1'b0;
         end else begin
            if (kept && !push && mOvf != 255) mOvf++;
            if (kept && clip) mSat = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("fill", {11'd0, fill}, 16'(expQ.size()));
      checkOutput("out_valid", {15'd0, out_valid}, {15'd0, expQ.size() != 0});
      checkOutput("ovf_cnt", {8'h00, ovf_cnt}, 16'(mOvf));
      checkOutput("sat_flag", {15'd0, sat_flag}, {15'd0, mSat});
      if (expQ.size() != 0) checkOutput("head", {8'h00, out_data}, {8'h00, expQ[0]});
      else if (justReset)   checkOutput("reset_data", {8'h00, out_data}, 16'h0000);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_stat = 1'b0;

      // Reset with active inputs, which must be ignored
      applyStimulus(1'b0, 1'b1, 16'h0F00, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Continuous stream, draining consumer: 0x10 and 0x30 emerge
      applyStimulus(1'b1, 1'b1, 16'h0100, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0200, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0300, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0400, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Saturating sample, then statistic clear leaves the FIFO alone
      applyStimulus(1'b1, 1'b1, 16'h1000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Fill past capacity with a stalled consumer, then drain in order
      for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 1'b1, 16'(i * 16'h0110), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)   applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Full FIFO with simultaneous push and pop
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++)  applyStimulus(1'b1, 1'b1, 16'(i * 16'h0120), 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0AB0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++)   applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Gapped valid pattern 1,0,0,1,1: phase holds across the gaps
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0110, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0220, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0330, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0440, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0550, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)   applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Overflow, reach fill=3 with phase=1, then reset mid-operation
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 1'b1, 16'(i * 16'h0130), 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0EE0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0770, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0500, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
